// File: rtl/exe_mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exe_mul_pkg : shared types and constants for the EXE multiply sequencer
// rev 1.0
// ---------------------------------------------------------------------------
package exe_mul_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_ACC  = 2'd2,
      MUL_DONE = 2'd3
   } mul_state_t;

   localparam int MUL_ITERS = 32;
   localparam int MUL_CNT_W = 6;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_shift_add_core : operand registers, radix-2 shift-add datapath, counter
// rev 1.0
// ---------------------------------------------------------------------------
module mul_shift_add_core
   import exe_mul_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic        add_rn,
   input  logic [31:0] rm_in,
   input  logic [31:0] rs_in,
   input  logic [31:0] rn_in,
   output logic [31:0] step_sum,
   output logic [31:0] rn_sum,
   output logic        last_iter
);

   logic [31:0]          r_mcand;
   logic [31:0]          r_mplier;
   logic [31:0]          r_addend;
   logic [31:0]          r_acc;
   logic [MUL_CNT_W-1:0] r_cnt;

   logic                 w_cnt_last;
   logic                 w_mplier_empty;

   assign step_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign rn_sum   = r_acc + r_addend;

   // Early exit looks at the multiplier as it will be after this cycle's shift.
   assign w_cnt_last     = (r_cnt == MUL_CNT_W'(MUL_ITERS - 1));
   assign w_mplier_empty = (r_mplier[31:1] == 31'd0);
   assign last_iter      = w_cnt_last || (EARLY_TERM && w_mplier_empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
         r_addend <= 32'd0;
         r_acc    <= 32'd0;
         r_cnt    <= '0;
      end else if (load) begin
         r_mcand  <= rm_in;
         r_mplier <= rs_in;
         r_addend <= rn_in;
         r_acc    <= 32'd0;
         r_cnt    <= '0;
      end else if (step) begin
         r_acc    <= step_sum;
         r_mcand  <= {r_mcand[30:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[31:1]};
         r_cnt    <= r_cnt + MUL_CNT_W'(1);
      end else if (add_rn) begin
         r_acc    <= rn_sum;
      end
   end

endmodule
`default_nettype wire

// File: rtl/exe_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exe_mul_seq : multi-cycle MUL/MLA sequencer with pipeline stall and flags
// rev 1.0
// ---------------------------------------------------------------------------
module exe_mul_seq
   import exe_mul_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        accumulate,
   input  logic        set_flags,
   input  logic [31:0] Val_Rm,
   input  logic [31:0] Val_Rs,
   input  logic [31:0] Val_Rn,
   input  logic        C_in,
   input  logic        V_in,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        flags_wr,
   output logic [31:0] result,
   output logic        N_out,
   output logic        Z_out,
   output logic        C_out,
   output logic        V_out
);

   localparam logic [1:0] c_IDLE = MUL_IDLE;
   localparam logic [1:0] c_RUN  = MUL_RUN;
   localparam logic [1:0] c_ACC  = MUL_ACC;
   localparam logic [1:0] c_DONE = MUL_DONE;

   logic [1:0]  r_state;
   logic [1:0]  w_next;

   logic        r_accumulate;
   logic        r_set_flags;
   logic        r_c_in;
   logic        r_v_in;

   logic [31:0] r_result;
   logic        r_n;
   logic        r_z;
   logic        r_c;
   logic        r_v;

   logic        w_idle;
   logic        w_load;
   logic        w_step;
   logic        w_add;
   logic        w_last;
   logic        w_capture;
   logic [31:0] w_step_sum;
   logic [31:0] w_rn_sum;
   logic [31:0] w_final;

   assign w_idle = (r_state == c_IDLE);
   assign w_load = w_idle && start;
   assign w_step = (r_state == c_RUN);
   assign w_add  = (r_state == c_ACC);

   mul_shift_add_core #(
      .EARLY_TERM (EARLY_TERM)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .step      (w_step),
      .add_rn    (w_add),
      .rm_in     (Val_Rm),
      .rs_in     (Val_Rs),
      .rn_in     (Val_Rn),
      .step_sum  (w_step_sum),
      .rn_sum    (w_rn_sum),
      .last_iter (w_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (start) w_next = c_RUN;
         c_RUN:   if (w_last) w_next = r_accumulate ? c_ACC : c_DONE;
         c_ACC:   w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // The output register is loaded on the edge into DONE, so it holds afterwards.
   assign w_capture = (w_step && w_last && !r_accumulate) || w_add;
   assign w_final   = w_add ? w_rn_sum : w_step_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_IDLE;
         r_accumulate <= 1'b0;
         r_set_flags  <= 1'b0;
         r_c_in       <= 1'b0;
         r_v_in       <= 1'b0;
         r_result     <= 32'd0;
         r_n          <= 1'b0;
         r_z          <= 1'b0;
         r_c          <= 1'b0;
         r_v          <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_accumulate <= accumulate;
            r_set_flags  <= set_flags;
            r_c_in       <= C_in;
            r_v_in       <= V_in;
         end
         if (w_capture) begin
            r_result <= w_final;
            r_n      <= w_final[31];
            r_z      <= (w_final == 32'd0);
            r_c      <= r_c_in;
            r_v      <= r_v_in;
         end
      end
   end

   assign busy     = !w_idle;
   assign stall    = w_load || w_step || w_add;
   assign done     = (r_state == c_DONE);
   assign flags_wr = done && r_set_flags;
   assign result   = r_result;
   assign N_out    = r_n;
   assign Z_out    = r_z;
   assign C_out    = r_c;
   assign V_out    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_exe_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_exe_mul_seq : scoreboard bench, one instance per EARLY_TERM setting
// rev 1.0
// ---------------------------------------------------------------------------
module tb_exe_mul_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  start_v;
   logic        accumulate;
   logic        set_flags;
   logic [31:0] Val_Rm, Val_Rs, Val_Rn;
   logic        C_in, V_in;

   logic [1:0]  busy_v, stall_v, done_v, fw_v, n_v, z_v, c_v, v_v;
   logic [31:0] res_v [2];

   exe_mul_seq #(.EARLY_TERM(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .accumulate(accumulate),
      .set_flags(set_flags), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Val_Rn(Val_Rn),
      .C_in(C_in), .V_in(V_in), .busy(busy_v[0]), .stall(stall_v[0]),
      .done(done_v[0]), .flags_wr(fw_v[0]), .result(res_v[0]),
      .N_out(n_v[0]), .Z_out(z_v[0]), .C_out(c_v[0]), .V_out(v_v[0]));

   exe_mul_seq #(.EARLY_TERM(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .accumulate(accumulate),
      .set_flags(set_flags), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Val_Rn(Val_Rn),
      .C_in(C_in), .V_in(V_in), .busy(busy_v[1]), .stall(stall_v[1]),
      .done(done_v[1]), .flags_wr(fw_v[1]), .result(res_v[1]),
      .N_out(n_v[1]), .Z_out(z_v[1]), .C_out(c_v[1]), .V_out(v_v[1]));

   typedef struct {
      logic [31:0] res;
      logic        n, z, c, v, fw;
      int          cyc;
      int          id;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   tests  = 0;
   int   failed = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input int id, input logic [31:0] r, input logic n, z, c, v, fw,
                               input int at);
      exp_t e;
      e.res = r; e.n = n; e.z = z; e.c = c; e.v = v; e.fw = fw; e.cyc = at; e.id = id;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (done_v[i]) begin
               exp_t e;
               int   sz;
               sz = (i == 0) ? q0.size() : q1.size();
               if (sz == 0) begin
                  tests++;
                  failed++;
                  $display("FAIL dut%0d_unexpected_done: actual done=1 required done=0 (cycle %0d)", i, cyc);
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.cyc));
                  chk($sformatf("op%0d_result", e.id), res_v[i], e.res);
                  chk($sformatf("op%0d_N", e.id), n_v[i], e.n);
                  chk($sformatf("op%0d_Z", e.id), z_v[i], e.z);
                  chk($sformatf("op%0d_C", e.id), c_v[i], e.c);
                  chk($sformatf("op%0d_V", e.id), v_v[i], e.v);
                  chk($sformatf("op%0d_flags_wr", e.id), fw_v[i], e.fw);
                  chk($sformatf("op%0d_stall_in_done", e.id), stall_v[i], 1'b0);
               end
            end
         end
      end
   end

   // Call at a falling edge with the target idle; returns one cycle after start.
   task automatic issue(input int d, input int id, input logic [31:0] a, b, rn,
                        input logic acc, sf, ci, vi, input int lat,
                        input logic [31:0] er, input logic en, ez);
      Val_Rm = a; Val_Rs = b; Val_Rn = rn;
      accumulate = acc; set_flags = sf; C_in = ci; V_in = vi;
      start_v[d] = 1'b1;
      if (d == 0) q0.push_back(mk(id, er, en, ez, ci, vi, sf, cyc + lat));
      else        q1.push_back(mk(id, er, en, ez, ci, vi, sf, cyc + lat));
      #1 chk($sformatf("op%0d_stall_cycle0", id), stall_v[d], 1'b1);
      @(negedge clk);
      start_v[d] = 1'b0;
      // Scramble inputs: latched operands must not follow them.
      Val_Rm = ~a; Val_Rs = ~b; Val_Rn = ~rn;
      accumulate = ~acc; set_flags = ~sf; C_in = ~ci; V_in = ~vi;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || busy_v != 2'b00) && n < 300) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 300) begin
         failed++;
         $display("FAIL wait_idle_timeout: actual %0d cycles required <300", n);
      end
   endtask

   initial begin
      rst = 1'b1; start_v = 2'b00; accumulate = 1'b0; set_flags = 1'b0;
      Val_Rm = 32'd0; Val_Rs = 32'd0; Val_Rn = 32'd0; C_in = 1'b0; V_in = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d_rst_busy", i), busy_v[i], 1'b0);
         chk($sformatf("dut%0d_rst_stall", i), stall_v[i], 1'b0);
         chk($sformatf("dut%0d_rst_done", i), done_v[i], 1'b0);
         chk($sformatf("dut%0d_rst_flags_wr", i), fw_v[i], 1'b0);
         chk($sformatf("dut%0d_rst_result", i), res_v[i], 32'd0);
         chk($sformatf("dut%0d_rst_flags", i), {n_v[i], z_v[i], c_v[i], v_v[i]}, 4'b0000);
      end
      rst = 1'b0;
      @(negedge clk);

      // MUL 7 x 6, stall profile over the whole operation
      issue(0, 1, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 33, 32'd42, 1'b0, 1'b0);
      for (int k = 1; k <= 33; k++) begin
         #1 chk($sformatf("op1_stall_cycle%0d", k), stall_v[0], (k < 33) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      wait_idle();

      // MLA wrap-around, no flag write
      issue(0, 2, 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 34,
            32'h0000_0003, 1'b0, 1'b0);
      wait_idle();

      // Negative result, C/V pass-through
      issue(0, 3, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 33,
            32'h8000_0000, 1'b1, 1'b0);
      wait_idle();

      // Early termination instance
      issue(1, 4, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'd0, 1'b0, 1'b1);
      wait_idle();
      issue(1, 5, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 32'd15, 1'b0, 1'b0);
      wait_idle();
      issue(1, 6, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 33,
            32'h8000_0000, 1'b1, 1'b0);
      wait_idle();
      issue(1, 7, 32'd10, 32'd1, 32'hFFFF_FFF6, 1'b1, 1'b1, 1'b0, 0, 3, 32'd0, 1'b0, 1'b1);
      wait_idle();

      // Result held in IDLE, then aborted op with an ignored restart
      chk("dut0_result_held", res_v[0], 32'h8000_0000);
      Val_Rm = 32'd7; Val_Rs = 32'd6; Val_Rn = 32'd0; accumulate = 1'b0; set_flags = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      Val_Rm = 32'd9; Val_Rs = 32'd9; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("abort_busy_cycle6", busy_v[0], 1'b1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy_v[0], 1'b0);
      chk("abort_stall", stall_v[0], 1'b0);
      chk("abort_result", res_v[0], 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_still_idle", busy_v[0], 1'b0);

      // start held high: back-to-back operations
      Val_Rm = 32'd2; Val_Rs = 32'd3; Val_Rn = 32'd0; accumulate = 1'b0; set_flags = 1'b1;
      C_in = 1'b0; V_in = 1'b0;
      start_v[0] = 1'b1;
      q0.push_back(mk(8, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cyc + 33));
      q0.push_back(mk(9, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cyc + 67));
      repeat (67) @(negedge clk);
      start_v[0] = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
